// File: rtl/bank_desk_scheduler.sv
// bank_desk_scheduler
// Issues per-service ticket numbers, keeps one FIFO per service and hands
// waiting tickets to officer desks that ask for their next customer.
//
// Ports
//   clk, rst        system clock, asynchronous active-high reset
//   issue_valid     single-cycle request for a new ticket
//   issue_service   0 general, 1 loan, 2 customer service, 3 illegal
//   desk_req        per-desk "next customer" pulse
//   issue_ack       ticket queued, issue_ticket holds its number
//   issue_reject    queue full or illegal service
//   call_valid      one-cycle call pulse; call_ticket/desk/service hold
//   desk_busy       desk is serving a customer
//   wait_cnt        waiting count per service, 4 bits each
//   wait_total      sum of the three waiting counts
//
// Desk FSM
//   state      | meaning
//   IDLE       | no customer, not asking
//   PENDING    | asked for a customer, waiting for a grant
//   SERVING    | a ticket was called to this desk
module bank_desk_scheduler #(
  parameter int          QDEPTH   = 8,
  parameter logic [11:0] DESK_CAP = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  input  logic [1:0]  issue_service,
  input  logic [3:0]  desk_req,
  output logic        issue_ack,
  output logic        issue_reject,
  output logic [6:0]  issue_ticket,
  output logic        call_valid,
  output logic [6:0]  call_ticket,
  output logic [1:0]  call_desk,
  output logic [1:0]  call_service,
  output logic [3:0]  desk_busy,
  output logic [11:0] wait_cnt,
  output logic [4:0]  wait_total
);

  localparam int         AW       = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [3:0] QDEPTH_C = 4'(QDEPTH);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_SERVING = 2'd2;

  logic [6:0]    ticket_ctr;
  logic [6:0]    q_mem [3][QDEPTH];
  logic [AW-1:0] q_rd  [3];
  logic [AW-1:0] q_wr  [3];
  logic [3:0]    q_cnt [3];
  logic [3:0]    cnt_nxt [3];
  logic [6:0]    q_head [3];
  logic [1:0]    desk_st [4];
  logic [1:0]    desk_ptr;
  logic [1:0]    svc_ptr;

  logic [2:0]    q_nonempty;
  logic [2:0]    avail [4];
  logic [3:0]    elig;
  logic          issue_legal;
  logic [3:0]    issue_cnt;
  logic          issue_ok;
  logic [2:0]    push;
  logic [2:0]    pop;
  logic          grant;
  logic [1:0]    g_desk;
  logic [1:0]    g_svc;
  logic [3:0]    g_avail;
  logic [6:0]    g_head;
  logic [1:0]    s_ord0, s_ord1, s_ord2;
  logic [4:0]    total_nxt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    issue_legal = 1'b0;
    issue_cnt   = 4'd0;
    case (issue_service)
      2'd0: begin issue_legal = 1'b1; issue_cnt = q_cnt[0]; end
      2'd1: begin issue_legal = 1'b1; issue_cnt = q_cnt[1]; end
      2'd2: begin issue_legal = 1'b1; issue_cnt = q_cnt[2]; end
      default: ;
    endcase
  end

  // Full check uses the pre-edge count, so a same-cycle pop never frees room.
  assign issue_ok = issue_valid && issue_legal && (issue_cnt < QDEPTH_C);

  always_comb begin
    for (int s = 0; s < 3; s++) begin
      q_nonempty[s] = (q_cnt[s] != 4'd0);
      q_head[s]     = q_mem[s][q_rd[s]];
    end
    for (int d = 0; d < 4; d++) begin
      avail[d] = DESK_CAP[3*d +: 3] & q_nonempty;
      elig[d]  = (desk_st[d] == ST_PENDING) && (avail[d] != 3'b000);
    end
  end

  // Service visiting order starting at svc_ptr (always 0..2).
  assign s_ord0 = svc_ptr;
  assign s_ord1 = (svc_ptr == 2'd2) ? 2'd0 : svc_ptr + 2'd1;
  assign s_ord2 = (svc_ptr == 2'd0) ? 2'd2 : svc_ptr - 2'd1;

  always_comb begin
    grant  = 1'b0;
    g_desk = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (!grant && elig[2'(desk_ptr + 2'(i))]) begin
        grant  = 1'b1;
        g_desk = 2'(desk_ptr + 2'(i));
      end
    end
    g_avail = {1'b0, avail[g_desk]};
    if (g_avail[s_ord0])      g_svc = s_ord0;
    else if (g_avail[s_ord1]) g_svc = s_ord1;
    else                      g_svc = s_ord2;
    case (g_svc)
      2'd0:    g_head = q_head[0];
      2'd1:    g_head = q_head[1];
      default: g_head = q_head[2];
    endcase
  end

  always_comb begin
    for (int s = 0; s < 3; s++) begin
      push[s]    = issue_ok && (issue_service == 2'(s));
      pop[s]     = grant && (g_svc == 2'(s));
      cnt_nxt[s] = q_cnt[s] + {3'b000, push[s]} - {3'b000, pop[s]};
    end
    total_nxt = 5'(cnt_nxt[0]) + 5'(cnt_nxt[1]) + 5'(cnt_nxt[2]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ticket_ctr   <= 7'd1;
      desk_ptr     <= 2'd0;
      svc_ptr      <= 2'd0;
      issue_ack    <= 1'b0;
      issue_reject <= 1'b0;
      issue_ticket <= 7'd0;
      call_valid   <= 1'b0;
      call_ticket  <= 7'd0;
      call_desk    <= 2'd0;
      call_service <= 2'd0;
      wait_total   <= 5'd0;
      for (int s = 0; s < 3; s++) begin
        q_rd[s]  <= '0;
        q_wr[s]  <= '0;
        q_cnt[s] <= 4'd0;
      end
      for (int d = 0; d < 4; d++) desk_st[d] <= ST_IDLE;
    end else begin
      issue_ack    <= issue_ok;
      issue_reject <= issue_valid && !issue_ok;
      if (issue_ok) begin
        issue_ticket <= ticket_ctr;
        ticket_ctr   <= (ticket_ctr == 7'd127) ? 7'd1 : ticket_ctr + 7'd1;
      end
      for (int s = 0; s < 3; s++) begin
        if (push[s]) q_wr[s] <= ptr_inc(q_wr[s]);
        if (pop[s])  q_rd[s] <= ptr_inc(q_rd[s]);
        q_cnt[s] <= cnt_nxt[s];
      end
      call_valid <= grant;
      if (grant) begin
        call_ticket  <= g_head;
        call_desk    <= g_desk;
        call_service <= g_svc;
        desk_ptr     <= g_desk + 2'd1;
        svc_ptr      <= (g_svc == 2'd2) ? 2'd0 : g_svc + 2'd1;
      end
      // A granted desk was PENDING, so its own request that cycle is moot.
      for (int d = 0; d < 4; d++) begin
        if (grant && (g_desk == 2'(d)))
          desk_st[d] <= ST_SERVING;
        else if (desk_req[d] && (desk_st[d] != ST_PENDING))
          desk_st[d] <= ST_PENDING;
      end
      wait_total <= total_nxt;
    end
  end

  // Queue storage needs no reset: entries are only read below the count.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (push[s]) q_mem[s][q_wr[s]] <= ticket_ctr;
    end
  end

  always_comb begin
    for (int d = 0; d < 4; d++) desk_busy[d] = (desk_st[d] == ST_SERVING);
  end

  assign wait_cnt = {q_cnt[2], q_cnt[1], q_cnt[0]};

endmodule

// File: tb/tb_bank_desk_scheduler.sv
// Testbench for bank_desk_scheduler: directed scenarios plus random traffic,
// compared every cycle with a queue-based model of the ticket/desk rules.
module tb_bank_desk_scheduler;
  localparam int QDEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [1:0]  issue_service;
  logic [3:0]  desk_req;
  logic        issue_ack, issue_reject, call_valid;
  logic [6:0]  issue_ticket, call_ticket;
  logic [1:0]  call_desk, call_service;
  logic [3:0]  desk_busy;
  logic [11:0] wait_cnt;
  logic [4:0]  wait_total;

  logic        c_issue_valid;
  logic [1:0]  c_issue_service;
  logic [3:0]  c_desk_req;
  logic        c_issue_ack, c_issue_reject, c_call_valid;
  logic [6:0]  c_issue_ticket, c_call_ticket;
  logic [1:0]  c_call_desk, c_call_service;
  logic [3:0]  c_desk_busy;
  logic [11:0] c_wait_cnt;
  logic [4:0]  c_wait_total;

  always #5 clk = ~clk;

  bank_desk_scheduler #(.QDEPTH(QDEPTH), .DESK_CAP(12'hFFF)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_service(issue_service),
    .desk_req(desk_req), .issue_ack(issue_ack), .issue_reject(issue_reject),
    .issue_ticket(issue_ticket), .call_valid(call_valid), .call_ticket(call_ticket),
    .call_desk(call_desk), .call_service(call_service), .desk_busy(desk_busy),
    .wait_cnt(wait_cnt), .wait_total(wait_total)
  );

  // Desk 0 serves loans only; other desks serve nothing.
  bank_desk_scheduler #(.QDEPTH(QDEPTH), .DESK_CAP(12'h002)) dut_cap (
    .clk(clk), .rst(rst), .issue_valid(c_issue_valid), .issue_service(c_issue_service),
    .desk_req(c_desk_req), .issue_ack(c_issue_ack), .issue_reject(c_issue_reject),
    .issue_ticket(c_issue_ticket), .call_valid(c_call_valid), .call_ticket(c_call_ticket),
    .call_desk(c_call_desk), .call_service(c_call_service), .desk_busy(c_desk_busy),
    .wait_cnt(c_wait_cnt), .wait_total(c_wait_total)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: desk state 0 idle, 1 waiting for a customer, 2 serving.
  logic [11:0] cap_main = 12'hFFF;
  int   mq [3][$];
  int   m_ctr, m_dptr, m_sptr, m_tk, m_ct, m_cd, m_cs, n_acks;
  int   m_st [4];
  logic m_ack, m_rej, m_cv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < 3; s++) mq[s].delete();
    for (int d = 0; d < 4; d++) m_st[d] = 0;
    m_ctr = 1; m_dptr = 0; m_sptr = 0;
    m_tk = 0; m_ct = 0; m_cd = 0; m_cs = 0;
    m_ack = 0; m_rej = 0; m_cv = 0;
  endfunction

  function automatic void model_step(input logic v, input logic [1:0] svc, input logic [3:0] req);
    int  pre [3];
    int  gd, gs;
    bit  got;
    for (int s = 0; s < 3; s++) pre[s] = mq[s].size();
    got = 0; gd = 0; gs = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      int d = (m_dptr + i) % 4;
      if (m_st[d] == 1) begin
        for (int j = 0; j < 3 && !got; j++) begin
          int s = (m_sptr + j) % 3;
          if (cap_main[3*d+s] && pre[s] > 0) begin got = 1; gd = d; gs = s; end
        end
      end
    end
    m_cv = got;
    if (got) begin
      m_ct = mq[gs].pop_front();
      m_cd = gd; m_cs = gs;
      m_dptr = (gd + 1) % 4;
      m_sptr = (gs + 1) % 3;
    end
    m_ack = 0; m_rej = 0;
    if (v) begin
      if (svc != 2'd3 && pre[svc] < QDEPTH) begin
        mq[svc].push_back(m_ctr);
        m_tk  = m_ctr;
        m_ctr = (m_ctr == 127) ? 1 : m_ctr + 1;
        m_ack = 1;
        n_acks++;
      end else begin
        m_rej = 1;
      end
    end
    for (int d = 0; d < 4; d++) begin
      if (got && gd == d)           m_st[d] = 2;
      else if (req[d] && m_st[d] != 1) m_st[d] = 1;
    end
  endfunction

  task automatic step(input logic v, input logic [1:0] svc, input logic [3:0] req);
    logic [3:0]  eb;
    logic [11:0] ew;
    issue_valid = v; issue_service = svc; desk_req = req;
    model_step(v, svc, req);
    @(posedge clk); #1;
    issue_valid = 0; issue_service = 0; desk_req = 0;
    for (int d = 0; d < 4; d++) eb[d] = (m_st[d] == 2);
    ew = {4'(mq[2].size()), 4'(mq[1].size()), 4'(mq[0].size())};
    check("issue_ack", issue_ack, m_ack);
    check("issue_reject", issue_reject, m_rej);
    check("issue_ticket", issue_ticket, m_tk);
    check("call_valid", call_valid, m_cv);
    check("call_ticket", call_ticket, m_ct);
    check("call_desk", call_desk, m_cd);
    check("call_service", call_service, m_cs);
    check("desk_busy", desk_busy, eb);
    check("wait_cnt", wait_cnt, ew);
    check("wait_total", wait_total, mq[0].size() + mq[1].size() + mq[2].size());
  endtask

  task automatic cstep(input logic v, input logic [1:0] svc, input logic [3:0] req);
    c_issue_valid = v; c_issue_service = svc; c_desk_req = req;
    @(posedge clk); #1;
    c_issue_valid = 0; c_issue_service = 0; c_desk_req = 0;
  endtask

  // Reset is raised between edges so its asynchronous effect is observed.
  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst_call_valid", call_valid, 0);
    check("rst_issue_ack", issue_ack, 0);
    check("rst_issue_ticket", issue_ticket, 0);
    check("rst_call_ticket", call_ticket, 0);
    check("rst_desk_busy", desk_busy, 0);
    check("rst_wait_cnt", wait_cnt, 0);
    check("rst_wait_total", wait_total, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0);
  endtask

  int exp_tk [4] = '{1, 3, 4, 2};
  int exp_sv [4] = '{0, 1, 2, 0};
  int guard;

  initial begin
    issue_valid = 0; issue_service = 0; desk_req = 0;
    c_issue_valid = 0; c_issue_service = 0; c_desk_req = 0;
    n_acks = 0;
    rst = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // First ticket after reset
    step(1, 0, 0);
    check("first_ticket", issue_ticket, 1);
    check("first_wait", wait_cnt[3:0], 1);

    // FIFO order with service round-robin at desk 0
    step(1, 0, 0); step(1, 1, 0); step(1, 2, 0);
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 4'b0001);
      step(0, 0, 0);
      check("fifo_call_valid", call_valid, 1);
      check("fifo_call_ticket", call_ticket, exp_tk[k]);
      check("fifo_call_service", call_service, exp_sv[k]);
      check("fifo_call_desk", call_desk, 0);
      step(0, 0, 0);
    end

    // Full queue and illegal service
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(1, 1, 0);
      check("full_ack", issue_ack, (k < 8) ? 1 : 0);
    end
    check("full_reject", issue_reject, 1);
    check("full_count", wait_cnt[7:4], 8);
    step(1, 0, 0);
    check("ctr_after_full", issue_ticket, 9);
    step(1, 3, 0);
    check("illegal_reject", issue_reject, 1);

    // All four desks request together
    do_reset();
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    step(0, 0, 4'b1111);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0);
      check("multi_valid", call_valid, 1);
      check("multi_desk", call_desk, k);
      check("multi_ticket", call_ticket, k + 1);
    end
    step(0, 0, 0);
    check("multi_idle", call_valid, 0);
    check("multi_busy", desk_busy, 4'b0111);
    step(1, 0, 0);
    check("multi_t4", issue_ticket, 4);
    step(0, 0, 0);
    check("desk3_valid", call_valid, 1);
    check("desk3_desk", call_desk, 3);
    check("desk3_ticket", call_ticket, 4);

    // Reset while two desks pending and a grant would be due next edge
    do_reset();
    step(0, 0, 4'b0011);
    step(1, 0, 0);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0);
      check("post_rst_nocall", call_valid, 0);
    end
    step(1, 0, 0);
    check("post_rst_ticket", issue_ticket, 1);

    // Counter wrap with pops interleaved
    do_reset();
    n_acks = 0;
    guard  = 0;
    while (n_acks < 127 && guard < 1000) begin
      step(1, 2'($urandom_range(0, 2)), 4'b1111);
      guard++;
    end
    check("wrap_reached", n_acks, 127);
    guard = 0;
    do begin
      step(1, 0, 4'b1111);
      guard++;
    end while (!issue_ack && guard < 20);
    check("wrap_ticket", issue_ticket, 1);

    // Random traffic against the model
    do_reset();
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0);
    end

    // Capability: desk 0 serves loans only
    do_reset();
    cstep(1, 0, 0);
    check("cap_ack", c_issue_ack, 1);
    cstep(0, 0, 4'b0001);
    for (int k = 0; k < 4; k++) begin
      cstep(0, 0, 0);
      check("cap_nocall", c_call_valid, 0);
    end
    check("cap_busy0", c_desk_busy, 0);
    cstep(1, 1, 0);
    check("cap_loan_ticket", c_issue_ticket, 2);
    cstep(0, 0, 0);
    check("cap_call_valid", c_call_valid, 1);
    check("cap_call_desk", c_call_desk, 0);
    check("cap_call_ticket", c_call_ticket, 2);
    check("cap_call_service", c_call_service, 1);
    check("cap_busy1", c_desk_busy, 4'b0001);
    check("cap_wait", c_wait_cnt, 12'h001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
